proj_tile_ctrl: RTL and testbench
=================================

PROJ_TILE_CTRL -- requirements
Module: proj_tile_ctrl

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
- M_TILES, 2, output row tiles per projection
- N_TILES, 2, output column tiles per projection
- K_TILES, 4, reduction tiles per output tile
- ADDR_W, 16, tile address width
REQ-002 Ports SHALL be, one per line: name, direction, width, meaning.
- clk  in  1  single clock, rising edge
- reset  in  1  asynchronous, active-high
- proj_start  in  1  one-cycle start pulse from the block sequencer
- proj_done  out  1  one-cycle completion pulse to the block sequencer
- busy  out  1  high from the cycle after start is accepted until proj_done is asserted
- proj_sel  out  2  current projection: 0=Q, 1=K, 2=V, 3=O
- rd_req  out  1  tile fetch request
- rd_ready  in  1  fetch accepted
- rd_addr_w  out  ADDR_W  weight tile address
- rd_addr_x  out  ADDR_W  activation tile address
- mac_clear  out  1  clear the accumulator
- mac_en  out  1  accumulate the fetched tile pair
- wr_req  out  1  result tile write request
- wr_ready  in  1  write accepted
- wr_addr  out  ADDR_W  result tile address
REQ-003 The block SHALL use one clock; reset SHALL be asynchronous and active-high, with ports named clk and reset.

Function
REQ-004 The FSM SHALL have the states IDLE, CLR, FETCH, MAC, WRITE, NEXT and DONE.
REQ-005 In IDLE, a proj_start sampled high SHALL move the FSM to CLR and zero the counters m, n and k.
REQ-006 proj_start SHALL be ignored in every state other than IDLE.
REQ-007 In CLR, mac_clear SHALL be high for exactly 1 cycle, k SHALL be zeroed, and the FSM SHALL then move to FETCH.
REQ-008 In FETCH, rd_req SHALL be high with stable addresses until rd_ready is sampled high, and the FSM SHALL then move to MAC.
REQ-009 In MAC, mac_en SHALL be high for exactly 1 cycle.
- If k == K_TILES-1, the FSM SHALL move to WRITE.
- Otherwise, k SHALL increment and the FSM SHALL move to FETCH.
REQ-010 In WRITE, wr_req SHALL be high with stable wr_addr until wr_ready is sampled high, and the FSM SHALL then move to NEXT.
REQ-011 In NEXT, n SHALL increment; when n wraps at N_TILES-1, m SHALL increment.
- If m == M_TILES-1 and n == N_TILES-1, the FSM SHALL move to DONE.
- Otherwise, the FSM SHALL move to CLR.
REQ-012 In DONE, proj_done SHALL be high for exactly 1 cycle, proj_sel SHALL increment (wrapping 3->0), and the FSM SHALL return to IDLE.
REQ-013 rd_addr_w SHALL equal proj_sel*N_TILES*K_TILES + n*K_TILES + k.
REQ-014 rd_addr_x SHALL equal m*K_TILES + k.
REQ-015 wr_addr SHALL equal proj_sel*M_TILES*N_TILES + m*N_TILES + n.
REQ-016 All addresses SHALL be truncated to ADDR_W bits and SHALL be 0 whenever the corresponding request is low.
REQ-017 rd_ready SHALL be ignored unless rd_req is high, and wr_ready SHALL be ignored unless wr_req is high.
REQ-018 With rd_ready and wr_ready tied high, each tile SHALL take 2*K_TILES+3 cycles.
REQ-019 With rd_ready and wr_ready tied high, proj_done SHALL be high in cycle M_TILES*N_TILES*(2*K_TILES+3)+1 after the proj_start sampling edge; with default parameters this is cycle 45.
REQ-020 mac_clear, mac_en, rd_req and wr_req SHALL be mutually exclusive in every cycle.

Reset
REQ-021 While reset is high, the FSM SHALL be in IDLE and all outputs and the counters m, n, k and proj_sel SHALL be 0.
REQ-022 Reset asserted mid-operation SHALL abort the operation immediately, with no proj_done pulse; after release, the next proj_start SHALL run with proj_sel=0.

Verification
REQ-023 The bench SHALL cover the following directed scenarios:
- Ready signals tied high, defaults, one proj_start -> proj_done exactly 45 cycles later, 4 wr_req pulses with wr_addr 0,1,2,3, and 16 mac_en pulses.
- Four consecutive runs -> proj_sel 0,1,2,3, then back to 0; the 4th run's first wr_addr is 12 and its first rd_addr_w is 24.
- rd_ready held low for 5 cycles on the first fetch -> rd_req and rd_addr_w=0 stable for 6 cycles, and proj_done delayed by 5 cycles to cycle 50.
- proj_start pulsed while busy -> ignored, with exactly one proj_done produced.
- Reset pulsed during WRITE of tile 2 -> all outputs 0 immediately and no proj_done; after release, a new run starts with proj_sel=0 and wr_addr=0.
- Spurious rd_ready/wr_ready pulses in IDLE -> no state change and no outputs asserted.

Source files
------------

// File: rtl/proj_tile_ctrl.sv
// Projection tile controller: walks the M x N output tiles of one projection
// (Q, K, V or O), fetching K reduction tile pairs into the MAC for each output
// tile and writing the result tile back before moving on.
module proj_tile_ctrl #(
   parameter int unsigned M_TILES = 2,
   parameter int unsigned N_TILES = 2,
   parameter int unsigned K_TILES = 4,
   parameter int unsigned ADDR_W  = 16
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              proj_start,
   output logic              proj_done,
   output logic              busy,
   output logic [1:0]        proj_sel,
   output logic              rd_req,
   input  logic              rd_ready,
   output logic [ADDR_W-1:0] rd_addr_w,
   output logic [ADDR_W-1:0] rd_addr_x,
   output logic              mac_clear,
   output logic              mac_en,
   output logic              wr_req,
   input  logic              wr_ready,
   output logic [ADDR_W-1:0] wr_addr
);

   // Counter widths; a single-tile dimension still needs a 1-bit counter.
   localparam int unsigned MW = (M_TILES > 1) ? $clog2(M_TILES) : 1;
   localparam int unsigned NW = (N_TILES > 1) ? $clog2(N_TILES) : 1;
   localparam int unsigned KW = (K_TILES > 1) ? $clog2(K_TILES) : 1;

   typedef enum logic [2:0] {
      StIdle,
      StClr,
      StFetch,
      StMac,
      StWrite,
      StNext,
      StDone
   } state_e;

   state_e        state_q;
   state_e        state_d;

   logic [MW-1:0] m_q;
   logic [NW-1:0] n_q;
   logic [KW-1:0] k_q;
   logic [1:0]    sel_q;

   logic          m_last;
   logic          n_last;
   logic          k_last;

   assign m_last = (m_q == MW'(M_TILES - 1));
   assign n_last = (n_q == NW'(N_TILES - 1));
   assign k_last = (k_q == KW'(K_TILES - 1));

   // State register.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic; ready inputs only matter in the state that raises the request.
   always_comb begin
      state_d = state_q;
      case (state_q)
         StIdle:  if (proj_start) state_d = StClr;
         StClr:   state_d = StFetch;
         StFetch: if (rd_ready) state_d = StMac;
         StMac:   state_d = k_last ? StWrite : StFetch;
         StWrite: if (wr_ready) state_d = StNext;
         StNext:  state_d = (m_last && n_last) ? StDone : StClr;
         StDone:  state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   // Tile counters and projection selector.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         m_q   <= '0;
         n_q   <= '0;
         k_q   <= '0;
         sel_q <= '0;
      end else begin
         case (state_q)
            StIdle: begin
               if (proj_start) begin
                  m_q <= '0;
                  n_q <= '0;
                  k_q <= '0;
               end
            end
            StClr: k_q <= '0;
            StMac: begin
               if (!k_last) k_q <= k_q + 1'b1;
            end
            StNext: begin
               // n is the inner loop; m advances when n wraps.
               if (n_last) begin
                  n_q <= '0;
                  m_q <= m_last ? '0 : m_q + 1'b1;
               end else begin
                  n_q <= n_q + 1'b1;
               end
            end
            StDone: sel_q <= sel_q + 1'b1;
            default: ;
         endcase
      end
   end

   // Moore outputs: the four datapath strobes are one per state, so they never overlap.
   always_comb begin
      proj_done = 1'b0;
      busy      = 1'b0;
      rd_req    = 1'b0;
      mac_clear = 1'b0;
      mac_en    = 1'b0;
      wr_req    = 1'b0;
      case (state_q)
         StClr: begin
            busy      = 1'b1;
            mac_clear = 1'b1;
         end
         StFetch: begin
            busy   = 1'b1;
            rd_req = 1'b1;
         end
         StMac: begin
            busy   = 1'b1;
            mac_en = 1'b1;
         end
         StWrite: begin
            busy   = 1'b1;
            wr_req = 1'b1;
         end
         StNext:  busy = 1'b1;
         StDone:  proj_done = 1'b1;
         default: ;
      endcase
   end

   assign proj_sel = sel_q;

   // Tile addresses, computed modulo 2^ADDR_W and forced to 0 while the request is idle.
   always_comb begin
      rd_addr_w = '0;
      rd_addr_x = '0;
      wr_addr   = '0;
      if (rd_req) begin
         rd_addr_w = ADDR_W'(sel_q) * ADDR_W'(N_TILES * K_TILES)
                   + ADDR_W'(n_q) * ADDR_W'(K_TILES)
                   + ADDR_W'(k_q);
         rd_addr_x = ADDR_W'(m_q) * ADDR_W'(K_TILES) + ADDR_W'(k_q);
      end
      if (wr_req) begin
         wr_addr = ADDR_W'(sel_q) * ADDR_W'(M_TILES * N_TILES)
                 + ADDR_W'(m_q) * ADDR_W'(N_TILES)
                 + ADDR_W'(n_q);
      end
   end

endmodule

// File: tb/tb_proj_tile_ctrl.sv
// Directed bench for proj_tile_ctrl with default parameters.
module tb_proj_tile_ctrl;

   localparam int AW = 16;

   logic          clk = 1'b0;
   logic          reset;
   logic          proj_start;
   logic          proj_done;
   logic          busy;
   logic [1:0]    proj_sel;
   logic          rd_req;
   logic          rd_ready;
   logic [AW-1:0] rd_addr_w;
   logic [AW-1:0] rd_addr_x;
   logic          mac_clear;
   logic          mac_en;
   logic          wr_req;
   logic          wr_ready;
   logic [AW-1:0] wr_addr;

   always #5 clk = ~clk;

   proj_tile_ctrl #(
      .M_TILES(2),
      .N_TILES(2),
      .K_TILES(4),
      .ADDR_W (AW)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .proj_start(proj_start),
      .proj_done (proj_done),
      .busy      (busy),
      .proj_sel  (proj_sel),
      .rd_req    (rd_req),
      .rd_ready  (rd_ready),
      .rd_addr_w (rd_addr_w),
      .rd_addr_x (rd_addr_x),
      .mac_clear (mac_clear),
      .mac_en    (mac_en),
      .wr_req    (wr_req),
      .wr_ready  (wr_ready),
      .wr_addr   (wr_addr)
   );

   int total = 0;
   int bad   = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // All outputs packed into one word.
   function automatic logic [63:0] obs();
      return {8'd0, proj_done, busy, proj_sel, rd_req, mac_clear, mac_en, wr_req,
              rd_addr_w, rd_addr_x, wr_addr};
   endfunction

   typedef struct {
      int         cyc;
      logic       done;
      logic       bsy;
      logic [1:0] sel;
      logic       rq;
      logic       clr;
      logic       en;
      logic       wq;
      logic [15:0] aw;
      logic [15:0] ax;
      logic [15:0] wa;
   } vec_t;

   vec_t vecs[$];

   function automatic vec_t mk(int c, logic d, logic b, logic [1:0] s, logic rq, logic clr,
                               logic en, logic wq, int aw, int ax, int wa);
      vec_t v;
      v.cyc = c; v.done = d; v.bsy = b; v.sel = s; v.rq = rq; v.clr = clr; v.en = en;
      v.wq = wq; v.aw = 16'(aw); v.ax = 16'(ax); v.wa = 16'(wa);
      return v;
   endfunction

   function automatic logic [63:0] expv(vec_t v);
      return {8'd0, v.done, v.bsy, v.sel, v.rq, v.clr, v.en, v.wq, v.aw, v.ax, v.wa};
   endfunction

   // Results of the last run_one call.
   int done_cyc;
   int n_done;
   int n_wr;
   int n_mac;
   int excl_bad;
   int wr_a[8];
   int first_rdw;
   int first_wra;
   int run_sel;
   int ff_len;
   int ff_bad;

   task automatic pulse_start();
      @(negedge clk);
      proj_start = 1'b1;
      @(negedge clk);
      proj_start = 1'b0;
   endtask

   // One full projection; rd_low holds rd_ready low for that many edges on the first
   // fetch, restart_at pulses proj_start in that cycle of the run.
   task automatic run_one(input int rd_low, input int restart_at);
      int cyc;
      int fstate;
      done_cyc = 0; n_done = 0; n_wr = 0; n_mac = 0; excl_bad = 0;
      first_rdw = -1; first_wra = -1; ff_len = 0; ff_bad = 0; fstate = 0;
      wr_ready = 1'b1;
      rd_ready = (rd_low == 0);
      pulse_start();
      run_sel = int'(proj_sel);
      cyc = 1;
      while (cyc <= 300 && done_cyc == 0) begin
         if ($countones({rd_req, mac_clear, mac_en, wr_req}) > 1) excl_bad++;
         if (mac_en) n_mac++;
         if (wr_req) begin
            if (first_wra < 0) first_wra = int'(wr_addr);
            if (n_wr < 8) wr_a[n_wr] = int'(wr_addr);
            n_wr++;
         end
         if (rd_req) begin
            if (first_rdw < 0) first_rdw = int'(rd_addr_w);
            if (fstate == 0) fstate = 1;
            if (fstate == 1) begin
               ff_len++;
               if (rd_addr_w != 0) ff_bad++;
               if (ff_len == rd_low + 1) rd_ready = 1'b1;
            end
         end else if (fstate == 1) begin
            fstate = 2;
         end
         if (proj_done) begin
            done_cyc = cyc;
            n_done++;
         end
         proj_start = (cyc == restart_at);
         @(negedge clk);
         cyc++;
      end
      proj_start = 1'b0;
      rd_ready   = 1'b1;
      repeat (50) begin
         if (proj_done) n_done++;
         @(negedge clk);
      end
   endtask

   initial begin
      int cyc;
      int cnt;
      int wr_seen;
      bit hit;

      reset = 1'b1; proj_start = 1'b0; rd_ready = 1'b0; wr_ready = 1'b0;

      // Cycle-exact trace of a proj_sel=0 run with ready tied high.
      vecs.push_back(mk( 1, 0, 1, 0, 0, 1, 0, 0, 0, 0, 0));
      vecs.push_back(mk( 2, 0, 1, 0, 1, 0, 0, 0, 0, 0, 0));
      vecs.push_back(mk( 3, 0, 1, 0, 0, 0, 1, 0, 0, 0, 0));
      vecs.push_back(mk( 8, 0, 1, 0, 1, 0, 0, 0, 3, 3, 0));
      vecs.push_back(mk(10, 0, 1, 0, 0, 0, 0, 1, 0, 0, 0));
      vecs.push_back(mk(11, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0));
      vecs.push_back(mk(12, 0, 1, 0, 0, 1, 0, 0, 0, 0, 0));
      vecs.push_back(mk(15, 0, 1, 0, 1, 0, 0, 0, 5, 1, 0));
      vecs.push_back(mk(21, 0, 1, 0, 0, 0, 0, 1, 0, 0, 1));
      vecs.push_back(mk(24, 0, 1, 0, 1, 0, 0, 0, 0, 4, 0));
      vecs.push_back(mk(32, 0, 1, 0, 0, 0, 0, 1, 0, 0, 2));
      vecs.push_back(mk(41, 0, 1, 0, 1, 0, 0, 0, 7, 7, 0));
      vecs.push_back(mk(43, 0, 1, 0, 0, 0, 0, 1, 0, 0, 3));
      vecs.push_back(mk(44, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0));
      vecs.push_back(mk(45, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
      vecs.push_back(mk(46, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0));

      repeat (2) @(negedge clk);
      check("reset_state", obs(), 64'd0);
      reset = 1'b0;

      // Single run, ready tied high.
      run_one(0, 0);
      check("a_done_cycle", done_cyc, 45);
      check("a_done_count", n_done, 1);
      check("a_wr_count", n_wr, 4);
      for (int i = 0; i < 4; i++) check($sformatf("a_wr_addr%0d", i), wr_a[i], i);
      check("a_mac_count", n_mac, 16);
      check("a_exclusive", excl_bad, 0);
      check("a_sel", run_sel, 0);

      // Three more back-to-back runs walk proj_sel through K, V, O.
      run_one(0, 0);
      check("b_sel", run_sel, 1);
      run_one(0, 0);
      check("c_sel", run_sel, 2);
      run_one(0, 0);
      check("d_sel", run_sel, 3);
      check("d_first_wr_addr", first_wra, 12);
      check("d_first_rd_addr_w", first_rdw, 24);
      check("sel_wrapped", proj_sel, 0);

      // First fetch stalled for 5 edges.
      run_one(5, 0);
      check("e_fetch_len", ff_len, 6);
      check("e_fetch_addr_stable", ff_bad, 0);
      check("e_done_cycle", done_cyc, 50);
      check("e_exclusive", excl_bad, 0);

      // Start pulse while busy must be ignored.
      run_one(0, 20);
      check("f_done_count", n_done, 1);
      check("f_done_cycle", done_cyc, 45);

      // Spurious ready pulses while idle.
      cnt = 0;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         rd_ready = (i % 2) == 0;
         wr_ready = (i % 2) != 0;
         if (busy || rd_req || wr_req || mac_en || mac_clear || proj_done ||
             rd_addr_w != 0 || rd_addr_x != 0 || wr_addr != 0) cnt++;
      end
      repeat (2) begin
         @(negedge clk);
         if (busy || rd_req || wr_req || mac_en || mac_clear || proj_done) cnt++;
      end
      check("idle_quiet", cnt, 0);
      check("idle_sel_kept", proj_sel, 2);

      // Reset during the third tile's write.
      rd_ready = 1'b1; wr_ready = 1'b1;
      pulse_start();
      cyc = 1; wr_seen = 0; hit = 1'b0;
      while (cyc < 100 && !hit) begin
         if (wr_req) begin
            wr_seen++;
            if (wr_seen == 3) hit = 1'b1;
         end
         if (!hit) begin
            @(negedge clk);
            cyc++;
         end
      end
      check("g_reached_write", hit, 1);
      check("g_write_addr", wr_addr, 10);
      reset = 1'b1;
      #1;
      check("g_reset_outputs", obs(), 64'd0);
      cnt = 0;
      repeat (20) begin
         @(negedge clk);
         if (proj_done || busy) cnt++;
      end
      reset = 1'b0;
      repeat (30) begin
         @(negedge clk);
         if (proj_done || busy) cnt++;
      end
      check("g_no_done", cnt, 0);

      // Post-reset run replayed against the cycle table.
      rd_ready = 1'b1; wr_ready = 1'b1;
      pulse_start();
      cyc = 1;
      foreach (vecs[i]) begin
         while (cyc < vecs[i].cyc) begin
            @(negedge clk);
            cyc++;
         end
         check($sformatf("vec_c%0d", vecs[i].cyc), obs(), expv(vecs[i]));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
